// File: rtl/alink_wb_if.sv
// rtl/alink_wb_if.sv - Wishbone bus bundle between the system bus and the ALINK register slave
// Carries the classic Wishbone request (CYC/STB/WE/LOCK/CTI/BTE/ADR/DAT/SEL)
// and response (ACK/ERR/RTY/DAT) signals; master drives requests, slave responds.
interface alink_wb_if;
    logic        ALINK_CYC_I;
    logic        ALINK_STB_I;
    logic        ALINK_WE_I;
    logic        ALINK_LOCK_I;
    logic [2:0]  ALINK_CTI_I;
    logic [1:0]  ALINK_BTE_I;
    logic [5:0]  ALINK_ADR_I;
    logic [31:0] ALINK_DAT_I;
    logic [3:0]  ALINK_SEL_I;
    logic        ALINK_ACK_O;
    logic        ALINK_ERR_O;
    logic        ALINK_RTY_O;
    logic [31:0] ALINK_DAT_O;

    modport slave (
        input  ALINK_CYC_I, ALINK_STB_I, ALINK_WE_I, ALINK_LOCK_I, ALINK_CTI_I,
               ALINK_BTE_I, ALINK_ADR_I, ALINK_DAT_I, ALINK_SEL_I,
        output ALINK_ACK_O, ALINK_ERR_O, ALINK_RTY_O, ALINK_DAT_O
    );

    modport master (
        output ALINK_CYC_I, ALINK_STB_I, ALINK_WE_I, ALINK_LOCK_I, ALINK_CTI_I,
               ALINK_BTE_I, ALINK_ADR_I, ALINK_DAT_I, ALINK_SEL_I,
        input  ALINK_ACK_O, ALINK_ERR_O, ALINK_RTY_O, ALINK_DAT_O
    );
endinterface

// File: rtl/alink_wb_slave.sv
// rtl/alink_wb_slave.sv - Wishbone register slave exposing ALINK FIFOs, status, mask and busy
// Ports:
//   clk, rst        : system clock, asynchronous active-high reset
//   wb              : Wishbone slave bundle (registered ACK/DAT_O, ERR/RTY tied 0)
//   txfifo_push/din : registered one-cycle TX FIFO write strobe and data
//   rxcnt/rxempty   : RX FIFO status inputs
//   txcnt/txfull    : TX FIFO status inputs
//   reg_flush       : registered one-cycle flush pulse
//   reg_mask        : PHY enable mask register
//   busy            : per-PHY busy vector
//   rxfifo_pop      : combinational RX FIFO read strobe
//   rxfifo_dout     : RX FIFO head word (first-word-fall-through)
module alink_wb_slave (
    input  logic        clk,
    input  logic        rst,
    alink_wb_if.slave   wb,
    output logic        txfifo_push,
    output logic [31:0] txfifo_din,
    input  logic [9:0]  rxcnt,
    input  logic        rxempty,
    input  logic [10:0] txcnt,
    output logic        reg_flush,
    input  logic        txfull,
    output logic [31:0] reg_mask,
    input  logic [31:0] busy,
    output logic        rxfifo_pop,
    input  logic [31:0] rxfifo_dout
);
    localparam logic [3:0] REG_TXFIFO = 4'd0;
    localparam logic [3:0] REG_STATE  = 4'd1;
    localparam logic [3:0] REG_MASK   = 4'd2;
    localparam logic [3:0] REG_BUSY   = 4'd3;
    localparam logic [3:0] REG_RXFIFO = 4'd4;

    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        push_q, push_d;
    logic [31:0] din_q, din_d;
    logic        flush_q, flush_d;
    logic [31:0] mask_q, mask_d;

    logic       acc;
    logic [3:0] reg_sel;

    // Qualifiers that the slave intentionally does not decode.
    logic unused_wb;
    assign unused_wb = ^{wb.ALINK_CYC_I, wb.ALINK_LOCK_I, wb.ALINK_CTI_I,
                         wb.ALINK_BTE_I, wb.ALINK_SEL_I, wb.ALINK_ADR_I[1:0]};

    // A held STB is taken once; the ACK cycle masks it so each access fires
    // exactly one set of side effects.
    assign acc     = wb.ALINK_STB_I & ~ack_q;
    assign reg_sel = wb.ALINK_ADR_I[5:2];

    // Pop while the head word is sampled into DAT_O on the same edge.
    assign rxfifo_pop = acc & ~wb.ALINK_WE_I & (reg_sel == REG_RXFIFO);

    always_comb begin
        ack_d   = acc;
        dat_d   = dat_q;
        push_d  = 1'b0;
        din_d   = din_q;
        flush_d = 1'b0;
        mask_d  = mask_q;
        if (acc) begin
            if (wb.ALINK_WE_I) begin
                case (reg_sel)
                    REG_TXFIFO: begin
                        push_d = 1'b1;
                        din_d  = wb.ALINK_DAT_I;
                    end
                    REG_STATE: flush_d = wb.ALINK_DAT_I[0];
                    REG_MASK:  mask_d  = wb.ALINK_DAT_I;
                    default:   ;
                endcase
            end else begin
                case (reg_sel)
                    REG_STATE:  dat_d = {rxempty, txfull, 4'b0, rxcnt, 5'b0, txcnt};
                    REG_MASK:   dat_d = mask_q;
                    REG_BUSY:   dat_d = busy;
                    REG_RXFIFO: dat_d = rxfifo_dout;
                    default:    dat_d = 32'h0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            dat_q   <= 32'h0;
            push_q  <= 1'b0;
            din_q   <= 32'h0;
            flush_q <= 1'b0;
            mask_q  <= 32'h0;
        end else begin
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            push_q  <= push_d;
            din_q   <= din_d;
            flush_q <= flush_d;
            mask_q  <= mask_d;
        end
    end

    assign wb.ALINK_ACK_O = ack_q;
    assign wb.ALINK_ERR_O = 1'b0;
    assign wb.ALINK_RTY_O = 1'b0;
    assign wb.ALINK_DAT_O = dat_q;
    assign txfifo_push    = push_q;
    assign txfifo_din     = din_q;
    assign reg_flush      = flush_q;
    assign reg_mask       = mask_q;
endmodule

// File: tb/tb_alink_wb_slave.sv
// tb/tb_alink_wb_slave.sv - self-checking bench for alink_wb_slave
module tb_alink_wb_slave;
    logic        clk = 1'b0;
    logic        rst;
    logic        txfifo_push;
    logic [31:0] txfifo_din;
    logic [9:0]  rxcnt;
    logic        rxempty;
    logic [10:0] txcnt;
    logic        reg_flush;
    logic        txfull;
    logic [31:0] reg_mask;
    logic [31:0] busy;
    logic        rxfifo_pop;
    logic [31:0] rxfifo_dout;

    alink_wb_if wb ();

    alink_wb_slave dut (
        .clk         (clk),
        .rst         (rst),
        .wb          (wb.slave),
        .txfifo_push (txfifo_push),
        .txfifo_din  (txfifo_din),
        .rxcnt       (rxcnt),
        .rxempty     (rxempty),
        .txcnt       (txcnt),
        .reg_flush   (reg_flush),
        .txfull      (txfull),
        .reg_mask    (reg_mask),
        .busy        (busy),
        .rxfifo_pop  (rxfifo_pop),
        .rxfifo_dout (rxfifo_dout)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int push_cnt = 0;
    int flush_cnt = 0;
    int pop_cnt = 0;
    logic [31:0] exp_q[$];

    // Pulse widths are counted mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (!rst) begin
            push_cnt  += int'(txfifo_push);
            flush_cnt += int'(reg_flush);
            pop_cnt   += int'(rxfifo_pop);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One Wishbone access; read data expectation goes through the scoreboard.
    task automatic wb_xfer(input bit we, input logic [5:0] adr, input logic [31:0] wd,
                           input logic [31:0] exp_rd, input bit hold);
        int n;
        logic [31:0] exp;
        @(posedge clk);
        #2;
        wb.ALINK_CYC_I = 1'b1;
        wb.ALINK_STB_I = 1'b1;
        wb.ALINK_WE_I  = we;
        wb.ALINK_ADR_I = adr;
        wb.ALINK_DAT_I = wd;
        if (!we) exp_q.push_back(exp_rd);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!wb.ALINK_ACK_O && n < 4);
        check("ack_latency", 32'(n), 32'd1);
        if (!we) begin
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hx;
            check("rd_data", wb.ALINK_DAT_O, exp);
        end
        check("err_rty", {30'b0, wb.ALINK_ERR_O, wb.ALINK_RTY_O}, 32'h0);
        if (hold) begin
            @(posedge clk);
            #1;
            check("ack_drop_held", {31'b0, wb.ALINK_ACK_O}, 32'h0);
        end
        wb.ALINK_STB_I = 1'b0;
        wb.ALINK_CYC_I = 1'b0;
        wb.ALINK_WE_I  = 1'b0;
    endtask

    typedef struct {
        bit          we;
        logic [5:0]  adr;
        logic [31:0] wdat;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int p0, f0, r0;
        vecs[0]  = '{1'b0, 6'h00, 32'h0,         32'h0};
        vecs[1]  = '{1'b0, 6'h04, 32'h0,         32'h8008_0005};
        vecs[2]  = '{1'b0, 6'h08, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 6'h0C, 32'h0,         32'h0F0F_1234};
        vecs[4]  = '{1'b0, 6'h14, 32'h0,         32'h0};
        vecs[5]  = '{1'b0, 6'h3C, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 6'h08, 32'hA5A5_0F0F, 32'h0};
        vecs[7]  = '{1'b0, 6'h08, 32'h0,         32'hA5A5_0F0F};
        vecs[8]  = '{1'b1, 6'h0C, 32'hFFFF_FFFF, 32'h0};
        vecs[9]  = '{1'b1, 6'h14, 32'h5555_AAAA, 32'h0};
        vecs[10] = '{1'b0, 6'h08, 32'h0,         32'hA5A5_0F0F};
        vecs[11] = '{1'b0, 6'h10, 32'h0,         32'hDEAD_BEEF};

        rst = 1'b1;
        wb.ALINK_CYC_I = 0; wb.ALINK_STB_I = 0; wb.ALINK_WE_I = 0; wb.ALINK_LOCK_I = 0;
        wb.ALINK_CTI_I = 0; wb.ALINK_BTE_I = 0; wb.ALINK_ADR_I = 0; wb.ALINK_DAT_I = 0;
        wb.ALINK_SEL_I = 4'hF;
        txcnt = 11'd5; rxcnt = 10'd8; txfull = 1'b0; rxempty = 1'b1;
        busy = 32'h0F0F_1234; rxfifo_dout = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'b0, wb.ALINK_ACK_O}, 32'h0);
        check("rst_dat", wb.ALINK_DAT_O, 32'h0);
        check("rst_strobes", {30'b0, txfifo_push, reg_flush}, 32'h0);
        check("rst_din", txfifo_din, 32'h0);
        check("rst_mask", reg_mask, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        p0 = push_cnt; f0 = flush_cnt; r0 = pop_cnt;
        for (int i = 0; i < 12; i++)
            wb_xfer(vecs[i].we, vecs[i].adr, vecs[i].wdat, vecs[i].exp_rd, 1'b0);
        @(posedge clk); #1;
        check("tbl_mask", reg_mask, 32'hA5A5_0F0F);
        check("tbl_push_cnt", 32'(push_cnt - p0), 32'd0);
        check("tbl_flush_cnt", 32'(flush_cnt - f0), 32'd0);
        check("tbl_pop_cnt", 32'(pop_cnt - r0), 32'd1);

        // STATE with different status inputs.
        txcnt = 11'h7FF; rxcnt = 10'h3FF; txfull = 1'b1; rxempty = 1'b0;
        wb_xfer(1'b0, 6'h04, 32'h0, 32'h43FF_07FF, 1'b0);

        // TX push with STB held across the ACK cycle.
        p0 = push_cnt;
        wb_xfer(1'b1, 6'h00, 32'h1234_5678, 32'h0, 1'b1);
        @(posedge clk); #1;
        check("tx_push_cnt", 32'(push_cnt - p0), 32'd1);
        check("tx_din", txfifo_din, 32'h1234_5678);

        // RX pop held across ACK: still a single pop.
        r0 = pop_cnt;
        rxfifo_dout = 32'hCAFE_F00D;
        wb_xfer(1'b0, 6'h10, 32'h0, 32'hCAFE_F00D, 1'b1);
        @(posedge clk); #1;
        check("rx_pop_cnt", 32'(pop_cnt - r0), 32'd1);

        // Flush pulse on DAT_I[0]=1 only.
        f0 = flush_cnt;
        wb_xfer(1'b1, 6'h04, 32'h0000_0001, 32'h0, 1'b0);
        @(posedge clk); #1;
        check("flush_one", 32'(flush_cnt - f0), 32'd1);
        f0 = flush_cnt;
        wb_xfer(1'b1, 6'h04, 32'hFFFF_FFFE, 32'h0, 1'b0);
        @(posedge clk); #1;
        check("flush_zero", 32'(flush_cnt - f0), 32'd0);
        check("mask_kept", reg_mask, 32'hA5A5_0F0F);

        // Reset during an access drops ACK and strobes without a clock edge.
        @(posedge clk); #2;
        wb.ALINK_STB_I = 1'b1; wb.ALINK_WE_I = 1'b1;
        wb.ALINK_ADR_I = 6'h00; wb.ALINK_DAT_I = 32'h0BAD_F00D;
        @(posedge clk); #1;
        check("pre_rst_push", {31'b0, txfifo_push}, 32'h1);
        rst = 1'b1;
        #1;
        check("async_ack", {31'b0, wb.ALINK_ACK_O}, 32'h0);
        check("async_push", {31'b0, txfifo_push}, 32'h0);
        check("async_flush", {31'b0, reg_flush}, 32'h0);
        check("async_mask", reg_mask, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ack", {31'b0, wb.ALINK_ACK_O}, 32'h1);
        check("post_rst_din", txfifo_din, 32'h0BAD_F00D);
        wb.ALINK_STB_I = 1'b0; wb.ALINK_WE_I = 1'b0;
        repeat (2) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
